// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one synchronous memory port between instruction fetch
//             and the load/store unit. At most one request is accepted per
//             cycle; read data returns one cycle later to its owner. A
//             starvation counter forces a fetch win after STARVE_MAX
//             consecutive losses, and a fetch flush squashes in-flight
//             fetch data.
//  Ports    : clk_i/rst_i          clock, async active-high reset
//             if_*                 fetch request / grant / response
//             ls_*                 load/store request / grant / response
//             mem_*                memory macro request and read data
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   // fetch requester
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   input  logic        if_flush_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   // load/store requester
   input  logic        ls_req_i,
   input  logic        ls_we_i,
   input  logic [3:0]  ls_be_i,
   input  logic [31:0] ls_addr_i,
   input  logic [31:0] ls_wdata_i,
   output logic        ls_gnt_o,
   output logic        ls_rvalid_o,
   output logic [31:0] ls_rdata_o,
   // memory port
   input  logic        mem_ready_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0] starve_cnt;
   logic       rsp_valid_q;
   logic       rsp_owner_q;   // 0 = fetch, 1 = load/store
   logic       flush_q;

   logic       fetch_sel;
   logic       ls_sel;
   logic       accept;

   // Winner selection. Everything is forced idle while reset is held so the
   // combinational outputs read 0 even if requesters keep their lines high.
   always_comb begin
      fetch_sel = 1'b0;
      ls_sel    = 1'b0;
      if (!rst_i) begin
         fetch_sel = if_req_i && (!ls_req_i || (starve_cnt == STARVE_LIM));
         ls_sel    = ls_req_i && !fetch_sel;
      end
      accept = (fetch_sel || ls_sel) && mem_ready_i;
   end

   assign if_gnt_o  = fetch_sel && mem_ready_i;
   assign ls_gnt_o  = ls_sel && mem_ready_i;

   // Memory fields follow the would-be winner even under backpressure.
   always_comb begin
      mem_req_o   = fetch_sel || ls_sel;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_addr_o  = 32'h0;
      mem_wdata_o = 32'h0;
      if (ls_sel) begin
         mem_we_o    = ls_we_i;
         mem_be_o    = ls_be_i;
         mem_addr_o  = ls_addr_i;
         mem_wdata_o = ls_wdata_i;
      end else if (fetch_sel) begin
         mem_be_o    = 4'hF;
         mem_addr_o  = if_addr_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         starve_cnt  <= 4'd0;
         rsp_valid_q <= 1'b0;
         rsp_owner_q <= 1'b0;
         flush_q     <= 1'b0;
      end else begin
         rsp_valid_q <= accept;
         if (accept) begin
            rsp_owner_q <= ls_sel;
         end
         // A flush coincident with the fetch grant must squash the response
         // even after the flush pulse itself has gone away.
         flush_q <= if_gnt_o && if_flush_i;
         if (if_gnt_o) begin
            starve_cnt <= 4'd0;
         end else if (ls_gnt_o && if_req_i && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
         end
      end
   end

   assign if_rvalid_o = rsp_valid_q && !rsp_owner_q && !if_flush_i && !flush_q;
   assign ls_rvalid_o = rsp_valid_q && rsp_owner_q;
   assign if_rdata_o  = mem_rdata_i;
   assign ls_rdata_o  = mem_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter. Directed scenarios
//             (solo fetch, starvation, store ack, backpressure, flush, async
//             reset) followed by randomized traffic, all compared against a
//             behavioural reference model of the arbitration rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_flush, if_gnt, if_rvalid;
   logic [31:0] if_addr, if_rdata;
   logic        ls_req, ls_we, ls_gnt, ls_rvalid;
   logic [3:0]  ls_be;
   logic [31:0] ls_addr, ls_wdata, ls_rdata;
   logic        mem_ready, mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
      .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
      .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_be_i(ls_be),
      .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
      .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
      .mem_ready_i(mem_ready), .mem_req_o(mem_req), .mem_we_o(mem_we),
      .mem_be_o(mem_be), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state: consecutive fetch losses and the one response
   // that may be outstanding from last cycle.
   int losses;
   bit pend_v, pend_ls, pend_fl;
   bit e_if_gnt, e_ls_gnt;
   bit obs_if_gnt;

   // One clock cycle: inputs are already set (posedge+1). Check outputs at
   // the negedge, advance the model at the posedge, then retire granted
   // requests and present fresh read data.
   task automatic tick();
      bit wf, wl, acc;
      @(negedge clk);
      wf = if_req && (!ls_req || losses >= STARVE_MAX);
      wl = ls_req && !wf;
      e_if_gnt = wf && mem_ready;
      e_ls_gnt = wl && mem_ready;
      obs_if_gnt = if_gnt;
      check("if_gnt", if_gnt, e_if_gnt);
      check("ls_gnt", ls_gnt, e_ls_gnt);
      check("mem_req", mem_req, wf || wl);
      check("mem_we", mem_we, wl ? ls_we : 1'b0);
      check("mem_be", mem_be, wl ? ls_be : (wf ? 4'hF : 4'h0));
      check("mem_addr", mem_addr, wl ? ls_addr : (wf ? if_addr : 32'h0));
      check("mem_wdata", mem_wdata, wl ? ls_wdata : 32'h0);
      check("if_rvalid", if_rvalid, pend_v && !pend_ls && !if_flush && !pend_fl);
      check("ls_rvalid", ls_rvalid, pend_v && pend_ls);
      if (pend_v && !pend_ls && !if_flush && !pend_fl) check("if_rdata", if_rdata, mem_rdata);
      if (pend_v && pend_ls) check("ls_rdata", ls_rdata, mem_rdata);
      @(posedge clk);
      acc = mem_ready && (wf || wl);
      if (acc) begin
         if (wf) losses = 0;
         else if (if_req && losses < STARVE_MAX) losses++;
      end
      pend_v  = acc;
      pend_ls = wl;
      pend_fl = wf && if_flush;
      #1;
      if (e_if_gnt) if_req = 1'b0;
      if (e_ls_gnt) ls_req = 1'b0;
      mem_rdata = $urandom;
   endtask

   task automatic new_fetch(input logic [31:0] a);
      if_req = 1'b1; if_addr = a;
   endtask

   task automatic new_ls(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
      ls_req = 1'b1; ls_we = we; ls_be = be; ls_addr = a; ls_wdata = d;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_mem_req"}, mem_req, 1'b0);
      check({tag, "_gnts"}, {if_gnt, ls_gnt}, 2'b00);
      check({tag, "_rvalids"}, {if_rvalid, ls_rvalid}, 2'b00);
      check({tag, "_we_be"}, {mem_we, mem_be}, 5'h0);
      check({tag, "_addr"}, mem_addr, 32'h0);
      check({tag, "_wdata"}, mem_wdata, 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] pattern;
      rst = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
      ls_req = 0; ls_we = 0; ls_be = 0; ls_addr = 0; ls_wdata = 0;
      mem_ready = 1'b1; mem_rdata = 0;
      losses = 0; pend_v = 0; pend_ls = 0; pend_fl = 0;
      #2;
      new_fetch(32'h44); new_ls(1'b1, 4'h5, 32'h88, 32'h1234);
      #5;
      check_idle("in_reset");
      if_req = 0; ls_req = 0;
      #6 rst = 1'b0;               // released between edges
      @(posedge clk); #1;

      // Solo fetch, back to back
      for (int i = 0; i < 3; i++) begin
         new_fetch(32'(i * 4));
         tick();
      end
      tick();

      // Conflict starvation: LSU x4, fetch, LSU
      pattern = '0;
      for (int i = 0; i < 6; i++) begin
         if (!if_req) new_fetch(32'h1000 + 32'(i * 4));
         new_ls(1'b0, 4'hF, 32'h2000 + 32'(i * 4), 32'h0);
         tick();
         pattern[i] = obs_if_gnt;
      end
      check("starve_pattern", {26'h0, pattern}, 32'h10);
      tick();

      // Store acknowledge
      new_ls(1'b1, 4'b0011, 32'h100, 32'hDEADBEEF);
      tick();
      tick();

      // Backpressure with both pending, then release
      new_fetch(32'h300); new_ls(1'b0, 4'hF, 32'h400, 32'h0);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (!ls_req) new_ls(1'b0, 4'hF, 32'h500 + 32'(i * 4), 32'h0);
         tick();
      end
      ls_req = 1'b0;
      for (int i = 0; i < 4 && (if_req || ls_req); i++) tick();

      // Flush in the grant cycle, LSU response right after
      new_fetch(32'h20); if_flush = 1'b1;
      tick();
      if_flush = 1'b0;
      new_ls(1'b0, 4'hF, 32'h40, 32'h0);
      tick();
      tick();
      // Flush in the response cycle
      new_fetch(32'h20);
      tick();
      if_flush = 1'b1;
      tick();
      if_flush = 1'b0;
      tick();

      // Randomized traffic
      for (int c = 0; c < 2000; c++) begin
         if (!if_req && ($urandom_range(0, 3) != 0))
            new_fetch({$urandom_range(0, 65535), 2'b00});
         if (!ls_req && ($urandom_range(0, 2) != 0))
            new_ls(1'($urandom), 4'($urandom), $urandom, $urandom);
         mem_ready = ($urandom_range(0, 3) != 0);
         if_flush  = ($urandom_range(0, 7) == 0);
         tick();
      end
      if_flush = 1'b0;
      mem_ready = 1'b1;

      // Async reset with a response in flight
      new_fetch(32'h600); new_ls(1'b0, 4'hF, 32'h700, 32'h0);
      tick();
      new_fetch(32'h604); new_ls(1'b0, 4'hF, 32'h704, 32'h0);
      #2 rst = 1'b1;
      #1 check_idle("async_rst");
      @(posedge clk); #2;
      check_idle("rst_held");
      @(negedge clk); #2;
      rst = 1'b0;
      if_req = 0; ls_req = 0;
      losses = 0; pend_v = 0; pend_ls = 0; pend_fl = 0;
      for (int i = 0; i < 3; i++) tick();
      new_fetch(32'h800);
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
